debounce_multi: RTL and testbench
=================================

Name: debounce_multi

Overview:
- Next-generation button/switch conditioner for the UART/AXI peripheral IP.
- Debounces BTN_WIDTH asynchronous inputs, each with its own synchroniser and stability counter; debounce time is not shared across channels.
- Provides a stable level, a press pulse and a release pulse per channel.
- Adds long-press detection, which the previous generation did not have. Feeds the register block and interrupt logic.

Parameters:
- BTN_WIDTH, 5, number of independent input channels.
- CNT_W, 16, width of each per-channel stability counter.
- STABLE_CNT, 32768, consecutive cycles a new level must persist before acceptance; legal range 2 to 2^CNT_W-1.
- ACTIVE_LOW, 0, 1 = inputs are active-low and are inverted before the synchroniser.
- LONG_W, 24, width of each per-channel hold counter.
- LONG_CNT, 6000000, cycles of debounced-high hold before a long press is flagged; legal range 1 to 2^LONG_W-1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- btn_in  input  BTN_WIDTH  raw asynchronous button inputs.
- btn_out  output  BTN_WIDTH  debounced stable level (1 = pressed).
- press_pulse  output  BTN_WIDTH  one-cycle pulse on accepted press.
- release_pulse  output  BTN_WIDTH  one-cycle pulse on accepted release.
- long_pulse  output  BTN_WIDTH  one-cycle pulse when hold reaches LONG_CNT.
- long_level  output  BTN_WIDTH  high from long_pulse until accepted release.

Behaviour:
- One clock domain (clk). rst is synchronous, active-high, sampled on the rising edge of clk.
- Reset: all synchroniser flops, counters and outputs go to 0, including btn_out, press_pulse, release_pulse, long_pulse and long_level.
- Input conditioning: x = btn_in XOR {BTN_WIDTH{ACTIVE_LOW}}. x passes through a 2-flop synchroniser s1 -> s2 per channel.
- Stability counter, per channel i, evaluated every cycle:
  - If s2[i] == btn_out[i]: cnt[i] <= 0.
  - Else if cnt[i] == STABLE_CNT-1: btn_out[i] <= s2[i], cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i] + 1.
- Any bounce back to the current level before acceptance clears the counter. Channels are fully independent; simultaneous changes on several channels are all handled in parallel.
- Latency: a clean edge first captured by s1 at clock edge k appears on btn_out after edge k+STABLE_CNT+1.
- Pulses are registered:
  - press_pulse[i] is high exactly in the first cycle btn_out[i] reads 1.
  - release_pulse[i] is high exactly in the first cycle btn_out[i] reads 0.
  - Press and release pulses on one channel are never high together.
- Hold counter, per channel:
  - hold[i] is cleared while btn_out[i] == 0.
  - While btn_out[i] == 1, hold[i] increments up to LONG_CNT and then saturates; it never wraps.
  - long_pulse[i] fires for one cycle in the cycle after hold[i] reaches LONG_CNT.
  - long_level[i] sets together with long_pulse[i] and clears in the same cycle release_pulse[i] is asserted.
  - A release before LONG_CNT produces no long_pulse.
- Reset mid-operation: all state is discarded. A button still held when rst deasserts is re-debounced from zero and produces a fresh press_pulse after the normal latency.
- Counter widths: cnt never exceeds STABLE_CNT-1; hold never exceeds LONG_CNT. No overflow is possible within the legal parameter ranges.

Optional Feature:
- Macro: DEBOUNCE_AUTOREPEAT_EN.
- Defined:
  - Adds parameter REPEAT_CNT (default 1500000) and a per-channel repeat counter.
  - After long_pulse[i], while btn_out[i] stays 1, press_pulse[i] re-fires for one cycle every REPEAT_CNT cycles. The first repeat occurs REPEAT_CNT cycles after long_pulse.
  - The repeat counter clears on release and on reset.
- Undefined: press_pulse fires only once per accepted press; no repeat logic is synthesised.

Test Plan:
- Reset and clean press: STABLE_CNT=8, LONG_CNT=20, hold rst=1 for 3 cycles, then drive btn_in[0] 0->1 clean.
  - btn_out[0]=1 at edge k+9.
  - press_pulse[0] high exactly 1 cycle.
  - Other channels stay 0.
- Bounce rejection: STABLE_CNT=8, toggle btn_in[1] every 5 cycles for 60 cycles, then hold 1.
  - No output change during toggling.
  - btn_out[1] rises 9 edges after the final stable edge is captured.
- Long press: STABLE_CNT=8, LONG_CNT=20, hold btn_in[2]=1 for 50 cycles, then release.
  - long_pulse[2] once, 21 cycles after btn_out[2] rises.
  - long_level[2] high until the release_pulse cycle.
  - A 15-cycle hold gives no long_pulse.
- ACTIVE_LOW=1: btn_in idle all-ones gives btn_out=0. Driving btn_in[3]=0 gives a press_pulse[3].
- Mid-operation reset: assert rst while btn_in[4] is held and cnt is partway.
  - All outputs are 0 the next cycle.
  - After deassert with the button still held, press_pulse[4] fires after full latency.
- DEBOUNCE_AUTOREPEAT_EN defined with REPEAT_CNT=10: a 60-cycle hold past long_pulse yields press_pulses every 10 cycles. With the macro undefined, exactly one press_pulse.

Source files
------------

// File: rtl/debounce_multi.sv
// -----------------------------------------------------------------------------
// debounce_multi
//
// Multi-channel button/switch conditioner. Every channel has its own input
// synchroniser, stability counter and hold counter. No timing state is shared
// between channels.
//
// Per channel the block produces:
//    btn_out       debounced level (1 = pressed)
//    press_pulse   one-cycle pulse in the first cycle btn_out reads 1
//    release_pulse one-cycle pulse in the first cycle btn_out reads 0
//    long_pulse    one-cycle pulse once the button has been held LONG_CNT cycles
//    long_level    high from long_pulse until the release is accepted
//
// Optional build macro: DEBOUNCE_AUTOREPEAT_EN
//    When defined, adds parameter REPEAT_CNT and a per-channel repeat counter.
//    After long_pulse, press_pulse re-fires every REPEAT_CNT cycles while the
//    button stays pressed. The first repeat comes REPEAT_CNT cycles after
//    long_pulse. When the macro is undefined, no repeat logic exists.
//
// Ports:
//    clk            system clock
//    rst            synchronous active-high reset
//    btn_in         raw asynchronous button inputs [BTN_WIDTH]
//    btn_out        debounced levels [BTN_WIDTH]
//    press_pulse    accepted-press pulses [BTN_WIDTH]
//    release_pulse  accepted-release pulses [BTN_WIDTH]
//    long_pulse     long-press pulses [BTN_WIDTH]
//    long_level     long-press held flags [BTN_WIDTH]
//
// Parameters:
//    BTN_WIDTH   number of channels
//    CNT_W       width of the stability counter
//    STABLE_CNT  cycles a new level must persist (2 .. 2^CNT_W-1)
//    ACTIVE_LOW  1 = raw inputs are inverted before the synchroniser
//    LONG_W      width of the hold counter
//    LONG_CNT    hold cycles before a long press (1 .. 2^LONG_W-1)
// -----------------------------------------------------------------------------
module debounce_multi #(
   parameter int BTN_WIDTH  = 5,
   parameter int CNT_W      = 16,
   parameter int STABLE_CNT = 32768,
   parameter bit ACTIVE_LOW = 1'b0,
   parameter int LONG_W     = 24,
   parameter int LONG_CNT   = 6000000
`ifdef DEBOUNCE_AUTOREPEAT_EN
   ,
   parameter int REPEAT_CNT = 1500000
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BTN_WIDTH-1:0] btn_in,
   output logic [BTN_WIDTH-1:0] btn_out,
   output logic [BTN_WIDTH-1:0] press_pulse,
   output logic [BTN_WIDTH-1:0] release_pulse,
   output logic [BTN_WIDTH-1:0] long_pulse,
   output logic [BTN_WIDTH-1:0] long_level
);

   // The stability counter counts 0 .. STABLE_CNT-1. The change is accepted on
   // the edge that would otherwise step past STABLE_LAST.
   localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CNT - 1);
   localparam logic [LONG_W-1:0] LONG_LAST   = LONG_W'(LONG_CNT);

`ifdef DEBOUNCE_AUTOREPEAT_EN
   localparam int               REP_W    = (REPEAT_CNT > 1) ? $clog2(REPEAT_CNT) : 1;
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CNT - 1);
`endif

   for (genvar i = 0; i < BTN_WIDTH; i++) begin : g_ch

      logic             x;
      logic             s1;
      logic             s2;
      logic             lvl;
      logic             prs;
      logic             rel;
      logic             lp;
      logic             ll;
      logic [CNT_W-1:0] cnt;
      logic [LONG_W-1:0] hold;

      logic             differ;
      logic             accept;
      logic             press_now;
      logic             rel_now;
      logic             long_now;
      logic             rep_fire;

      assign x = btn_in[i] ^ ACTIVE_LOW;

      // -------------------------------------------------------------------
      // Two-flop synchroniser
      // -------------------------------------------------------------------
      always_ff @(posedge clk) begin
         if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
         end else begin
            s1 <= x;
            s2 <= s1;
         end
      end

      // -------------------------------------------------------------------
      // Acceptance decode.
      // press_now and rel_now are true on the edge where btn_out changes.
      // That same edge registers the matching pulse, so each pulse appears
      // in the first cycle of the new level.
      // -------------------------------------------------------------------
      assign differ    = s2 ^ lvl;
      assign accept    = differ && (cnt == STABLE_LAST);
      assign press_now = accept && s2;
      assign rel_now   = accept && !s2;

      // A release on the same edge takes priority over a long press.
      // long_level blocks the pulse from repeating while hold is saturated.
      assign long_now  = lvl && !rel_now && !ll && (hold == LONG_LAST);

      // -------------------------------------------------------------------
      // Stability counter and debounced level
      // -------------------------------------------------------------------
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt <= '0;
            lvl <= 1'b0;
         end else if (!differ) begin
            cnt <= '0;
         end else if (accept) begin
            cnt <= '0;
            lvl <= s2;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end

      // -------------------------------------------------------------------
      // Hold counter. It saturates at LONG_CNT and does not wrap.
      // -------------------------------------------------------------------
      always_ff @(posedge clk) begin
         if (rst || !lvl) begin
            hold <= '0;
         end else if (hold != LONG_LAST) begin
            hold <= hold + LONG_W'(1);
         end
      end

`ifdef DEBOUNCE_AUTOREPEAT_EN
      // -------------------------------------------------------------------
      // Auto-repeat counter. It starts counting in the cycle after long_pulse
      // and fires every REPEAT_CNT cycles. A release clears it, and it
      // cannot fire on the release edge.
      // -------------------------------------------------------------------
      logic [REP_W-1:0] rep;

      assign rep_fire = ll && lvl && !rel_now && (rep == REP_LAST);

      always_ff @(posedge clk) begin
         if (rst || !lvl || !ll || rel_now) begin
            rep <= '0;
         end else if (rep == REP_LAST) begin
            rep <= '0;
         end else begin
            rep <= rep + REP_W'(1);
         end
      end
`else
      assign rep_fire = 1'b0;
`endif

      // -------------------------------------------------------------------
      // Registered event outputs
      // -------------------------------------------------------------------
      always_ff @(posedge clk) begin
         if (rst) begin
            prs <= 1'b0;
            rel <= 1'b0;
            lp  <= 1'b0;
            ll  <= 1'b0;
         end else begin
            prs <= press_now || rep_fire;
            rel <= rel_now;
            lp  <= long_now;
            if (rel_now) begin
               ll <= 1'b0;
            end else if (long_now) begin
               ll <= 1'b1;
            end
         end
      end

      assign btn_out[i]       = lvl;
      assign press_pulse[i]   = prs;
      assign release_pulse[i] = rel;
      assign long_pulse[i]    = lp;
      assign long_level[i]    = ll;

   end : g_ch

endmodule

// File: tb/tb_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_debounce_multi
//
// Directed testbench for debounce_multi. It uses STABLE_CNT=8 and LONG_CNT=20.
// A main instance (active-high) runs a table of {inputs, cycles, expected
// outputs} records and then several hand-written sequences. A second instance
// with ACTIVE_LOW=1 is checked for idle and press behaviour.
// -----------------------------------------------------------------------------
module tb_debounce_multi;

   localparam int W = 5;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] btn_in;
   logic [W-1:0] btn_out, press_pulse, release_pulse, long_pulse, long_level;
   logic [W-1:0] btn_al;
   logic [W-1:0] al_out, al_press, al_release, al_long, al_level;

   int checks   = 0;
   int failures = 0;
   int long_cnt  [W];
   int press_cnt [W];
   int overlap   = 0;

   always #5 clk = ~clk;

   debounce_multi #(
      .BTN_WIDTH (W),
      .CNT_W     (16),
      .STABLE_CNT(8),
      .ACTIVE_LOW(1'b0),
      .LONG_W    (24),
      .LONG_CNT  (20)
`ifdef DEBOUNCE_AUTOREPEAT_EN
      ,
      .REPEAT_CNT(10)
`endif
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btn_in       (btn_in),
      .btn_out      (btn_out),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .long_pulse   (long_pulse),
      .long_level   (long_level)
   );

   debounce_multi #(
      .BTN_WIDTH (W),
      .CNT_W     (16),
      .STABLE_CNT(8),
      .ACTIVE_LOW(1'b1),
      .LONG_W    (24),
      .LONG_CNT  (20)
`ifdef DEBOUNCE_AUTOREPEAT_EN
      ,
      .REPEAT_CNT(10)
`endif
   ) dut_al (
      .clk          (clk),
      .rst          (rst),
      .btn_in       (btn_al),
      .btn_out      (al_out),
      .press_pulse  (al_press),
      .release_pulse(al_release),
      .long_pulse   (al_long),
      .long_level   (al_level)
   );

   typedef struct {
      logic [W-1:0] btn;
      int           adv;
      logic [W-1:0] out;
      logic [W-1:0] prs;
      logic [W-1:0] rel;
      logic [W-1:0] lp;
      logic [W-1:0] ll;
   } vec_t;

   // Advance n clock edges. Outputs are sampled 1 time unit after each edge,
   // and pulse events are tallied for every cycle.
   task automatic step(input int n);
      for (int j = 0; j < n; j++) begin
         @(posedge clk);
         #1;
         for (int c = 0; c < W; c++) begin
            if (long_pulse[c] === 1'b1) long_cnt[c]++;
            if (press_pulse[c] === 1'b1) press_cnt[c]++;
         end
         if ((press_pulse & release_pulse) != '0) overlap++;
      end
   endtask

   task automatic chk(input string name, input int idx,
                      input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] got=%b expected=%b", name, idx, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", name, act, exp);
      end
   endtask

   vec_t vt[$];

   function automatic vec_t v(input logic [W-1:0] b, input int a,
                              input logic [W-1:0] o, input logic [W-1:0] p,
                              input logic [W-1:0] r, input logic [W-1:0] l,
                              input logic [W-1:0] h);
      vec_t t;
      t.btn = b; t.adv = a; t.out = o; t.prs = p; t.rel = r; t.lp = l; t.ll = h;
      return t;
   endfunction

   int exp_press_f;

   initial begin
      for (int c = 0; c < W; c++) begin
         long_cnt[c]  = 0;
         press_cnt[c] = 0;
      end

      // Channel 0: clean press, long press, hold past LONG_CNT, then release.
      // The press is accepted at edge r.
      vt.push_back(v(5'b00001,  9, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
      vt.push_back(v(5'b00001,  1, 5'b00001, 5'b00001, 5'b00000, 5'b00000, 5'b00000)); // r
      vt.push_back(v(5'b00001,  1, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000)); // r+1
      vt.push_back(v(5'b00001, 19, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000)); // r+20
      vt.push_back(v(5'b00001,  1, 5'b00001, 5'b00000, 5'b00000, 5'b00001, 5'b00001)); // r+21
      vt.push_back(v(5'b00001,  1, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00001)); // r+22
      vt.push_back(v(5'b00001, 28, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00001)); // r+50
      vt.push_back(v(5'b00000,  8, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00001));
      vt.push_back(v(5'b00000,  1, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00001));
      vt.push_back(v(5'b00000,  1, 5'b00000, 5'b00000, 5'b00001, 5'b00000, 5'b00000));
      vt.push_back(v(5'b00000,  1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
      // Channel 1: bounce every 5 cycles for 60 cycles, then a stable press.
      for (int b = 0; b < 6; b++) begin
         vt.push_back(v(5'b00010, 5, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
         vt.push_back(v(5'b00000, 5, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
      end
      vt.push_back(v(5'b00010,  9, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
      vt.push_back(v(5'b00010,  1, 5'b00010, 5'b00010, 5'b00000, 5'b00000, 5'b00000));
      vt.push_back(v(5'b00000,  9, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
      vt.push_back(v(5'b00000,  1, 5'b00000, 5'b00000, 5'b00010, 5'b00000, 5'b00000));
      // Channels 0 and 3 pressed and released together.
      vt.push_back(v(5'b01001,  9, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
      vt.push_back(v(5'b01001,  1, 5'b01001, 5'b01001, 5'b00000, 5'b00000, 5'b00000));
      vt.push_back(v(5'b00000, 10, 5'b00000, 5'b00000, 5'b01001, 5'b00000, 5'b00000));
      vt.push_back(v(5'b00000,  1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
      // Channel 2: 50-cycle hold with a long press, then a 15-cycle hold without one.
      vt.push_back(v(5'b00100, 10, 5'b00100, 5'b00100, 5'b00000, 5'b00000, 5'b00000)); // r
      vt.push_back(v(5'b00100, 20, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00000)); // r+20
      vt.push_back(v(5'b00100,  1, 5'b00100, 5'b00000, 5'b00000, 5'b00100, 5'b00100)); // r+21
      vt.push_back(v(5'b00100,  1, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00100));
      vt.push_back(v(5'b00100, 18, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00100)); // r+40
      vt.push_back(v(5'b00000,  9, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00100));
      vt.push_back(v(5'b00000,  1, 5'b00000, 5'b00000, 5'b00100, 5'b00000, 5'b00000));
      vt.push_back(v(5'b00000,  1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
      vt.push_back(v(5'b00100, 10, 5'b00100, 5'b00100, 5'b00000, 5'b00000, 5'b00000));
      vt.push_back(v(5'b00100,  5, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
      vt.push_back(v(5'b00000,  9, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00000));
      vt.push_back(v(5'b00000,  1, 5'b00000, 5'b00000, 5'b00100, 5'b00000, 5'b00000));
      vt.push_back(v(5'b00000, 15, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000));

      // Reset for 3 cycles
      rst    = 1'b1;
      btn_in = '0;
      btn_al = '1;
      step(3);
      chk("rst_out",     0, btn_out,       5'b00000);
      chk("rst_press",   0, press_pulse,   5'b00000);
      chk("rst_release", 0, release_pulse, 5'b00000);
      chk("rst_long",    0, long_pulse,    5'b00000);
      chk("rst_level",   0, long_level,    5'b00000);
      chk("rst_al_out",  0, al_out,        5'b00000);
      rst = 1'b0;

      // Table run
      foreach (vt[i]) begin
         btn_in = vt[i].btn;
         step(vt[i].adv);
         chk("tbl_out",     i, btn_out,       vt[i].out);
         chk("tbl_press",   i, press_pulse,   vt[i].prs);
         chk("tbl_release", i, release_pulse, vt[i].rel);
         chk("tbl_long",    i, long_pulse,    vt[i].lp);
         chk("tbl_level",   i, long_level,    vt[i].ll);
      end
      chk_int("long_count_ch0", long_cnt[0], 1);
      chk_int("long_count_ch1", long_cnt[1], 0);
      chk_int("long_count_ch2", long_cnt[2], 1);

      // Reset in mid-operation: ch0 pressed, ch4 partway through debounce
      btn_in = 5'b00001;
      step(10);
      chk("mid_pre_out", 0, btn_out, 5'b00001);
      btn_in = 5'b10001;
      step(5);
      chk("mid_partway_out",   0, btn_out,     5'b00001);
      chk("mid_partway_press", 0, press_pulse, 5'b00000);
      rst = 1'b1;
      step(1);
      chk("mid_rst_out",     0, btn_out,       5'b00000);
      chk("mid_rst_press",   0, press_pulse,   5'b00000);
      chk("mid_rst_release", 0, release_pulse, 5'b00000);
      chk("mid_rst_long",    0, long_pulse,    5'b00000);
      chk("mid_rst_level",   0, long_level,    5'b00000);
      rst = 1'b0;
      step(9);
      chk("mid_relatch_early", 0, btn_out, 5'b00000);
      step(1);
      chk("mid_relatch_out",   0, btn_out,     5'b10001);
      chk("mid_relatch_press", 0, press_pulse, 5'b10001);
      step(1);
      chk("mid_relatch_press_end", 0, press_pulse, 5'b00000);
      btn_in = 5'b00000;
      step(10);
      chk("mid_release", 0, release_pulse, 5'b10001);
      chk("mid_release_out", 0, btn_out, 5'b00000);
      step(1);

      // ACTIVE_LOW instance: idle all-ones reads as released.
      chk("al_idle_out", 0, al_out, 5'b00000);
      btn_al = 5'b10111;
      step(9);
      chk("al_press_early", 0, al_press, 5'b00000);
      step(1);
      chk("al_press", 0, al_press, 5'b01000);
      chk("al_out",   0, al_out,   5'b01000);
      step(1);
      chk("al_press_end", 0, al_press, 5'b00000);
      btn_al = 5'b11111;
      step(10);
      chk("al_release", 0, al_release, 5'b01000);

      // Auto-repeat: ch3 is held 60 cycles past long_pulse.
      press_cnt[3] = 0;
      btn_in = 5'b01000;
      step(10);
      chk("rep_press", 0, press_pulse, 5'b01000);
      step(21);
      chk("rep_long", 0, long_pulse, 5'b01000);
      step(60);
      btn_in = 5'b00000;
      step(10);
      chk("rep_release", 0, release_pulse, 5'b01000);
      step(2);
`ifdef DEBOUNCE_AUTOREPEAT_EN
      exp_press_f = 7;
`else
      exp_press_f = 1;
`endif
      chk_int("rep_press_count", press_cnt[3], exp_press_f);
      chk_int("press_release_overlap", overlap, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
